// File: rtl/mv_pack_pkg.sv
// Shared constants, FSM state type and lane-index sizing for the result packer.
package mv_pack_pkg;

    localparam int NUM_DEF = 16;
    localparam int DW_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } pack_state_t;

    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LANE_IDX_W = lane_idx_w(NUM_DEF);

endpackage

// File: rtl/mv_pack_fifo.sv
// Packed-word FIFO with fall-through read: the head entry is visible on rd_data
// the cycle after it is written. Writes into a full FIFO succeed only alongside a read.
module mv_pack_fifo #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign free    = CW'(DEPTH) - count_reg;
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mv_result_packer.sv
// Packs scalar dot-product results NUM per word into a FIFO for writeback.
// Define MV_PACK_RELU_EN to zero every negative-signed scalar before packing.
module mv_result_packer
    import mv_pack_pkg::*;
#(
    parameter int NUM   = NUM_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    total_len,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_room,
    output logic [NUM*DW-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IW  = lane_idx_w(NUM);
    localparam int FCW = $clog2(DEPTH) + 1;

    pack_state_t            state_reg;
    logic [IW-1:0]          idx_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       len_reg;
    logic [NUM-1:0][DW-1:0] lanes_reg;
    logic                   err_reg;
    logic                   done_reg;
    logic                   busy_reg;

    logic [DW-1:0]          scalar;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   final_scalar;
    logic                   word_done;
    logic                   collecting;
    logic                   push;
    logic                   pop;
    logic                   overflow;
    logic                   drained;
    logic [NUM-1:0][DW-1:0] push_word;
    logic [NUM*DW:0]        fifo_rd_word;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FCW-1:0]         fifo_free;

`ifdef MV_PACK_RELU_EN
    assign scalar = in_data[DW-1] ? '0 : in_data;
`else
    assign scalar = in_data;
`endif

    assign cnt_inc      = cnt_reg + 1'b1;
    assign final_scalar = (cnt_inc == len_reg);
    assign word_done    = (idx_reg == IW'(NUM - 1)) || final_scalar;
    assign collecting   = (state_reg == COLLECT) && in_valid;
    assign push         = collecting && word_done;
    assign pop          = out_valid && out_ready;
    assign overflow     = push && fifo_full && !pop;
    // In DRAIN nothing is pushed, so the last pop empties the FIFO this edge.
    assign drained      = fifo_empty || ((fifo_free == FCW'(DEPTH - 1)) && pop);

    // Unused upper lanes are already zero because lanes_reg is cleared per word.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
        assign push_word[gi] = (idx_reg == IW'(gi)) ? scalar : lanes_reg[gi];
    end

    mv_pack_fifo #(
        .WIDTH (NUM*DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({final_scalar, push_word}),
        .rd_en   (pop),
        .rd_data (fifo_rd_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_rd_word[NUM*DW-1:0];
    assign out_last  = !fifo_empty && fifo_rd_word[NUM*DW];
    assign in_room   = (fifo_free >= FCW'(2));
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            len_reg   <= '0;
            lanes_reg <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (overflow) err_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (in_valid) err_reg <= 1'b1;
                    if (start) begin
                        len_reg   <= total_len;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                        lanes_reg <= '0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= (total_len == '0) ? DRAIN : COLLECT;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        cnt_reg <= cnt_inc;
                        if (word_done) begin
                            lanes_reg <= '0;
                            idx_reg   <= '0;
                        end else begin
                            lanes_reg[idx_reg] <= scalar;
                            idx_reg            <= idx_reg + 1'b1;
                        end
                        if (final_scalar) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_valid) err_reg <= 1'b1;
                    if (drained) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
